branch_resolve: RTL and testbench

Sequential branch/jump resolution unit; reads the 4-bit `{zero, sign, carry, overflow}` flag vector the ALU produces on a SUB of rs1 − rs2 and decides RISC-V conditional branches BEQ/BNE/BLT/BGE/BLTU/BGEU, JAL and JALR. It registers the decision, computes the target and link addresses, and drives a redirect handshake to fetch followed by a counted pipeline flush. It sits between execute and fetch.

---
 rtl/branch_resolve.sv | 163 ++++++++++++++++
 tb/tb_branch_resolve.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolve.sv
// Branch/jump resolution: decides taken, drives the fetch redirect, then a counted flush.
// Optional BRANCH_RESOLVE_STATS_EN adds resolved/taken event counters.
module branch_resolve #(
    parameter int WIDTH        = 32,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             valid_in,
    output logic             ready_in,
    input  logic             is_branch,
    input  logic             is_jal,
    input  logic             is_jalr,
    input  logic [2:0]       funct3,
    input  logic [3:0]       flags,
    input  logic [WIDTH-1:0] pc,
    input  logic [WIDTH-1:0] imm,
    input  logic [WIDTH-1:0] rs1_val,
    output logic             resolved,
    output logic             taken,
    output logic [WIDTH-1:0] link_addr,
    output logic             redirect_valid,
    output logic [WIDTH-1:0] redirect_pc,
    input  logic             redirect_ready,
    output logic             flush,
    output logic [31:0]      stat_resolved,
    output logic [31:0]      stat_taken
);

    typedef enum logic [1:0] {
        IDLE,
        REDIRECT,
        FLUSH
    } state_t;

    localparam bit HAS_FLUSH = (FLUSH_CYCLES > 0);
    localparam logic [3:0] CNT_LOAD =
        HAS_FLUSH ? 4'(FLUSH_CYCLES - 1) : 4'd0;

    state_t           state;
    state_t           state_nxt;
    logic [3:0]       cnt;
    logic [3:0]       cnt_nxt;
    logic             accept;
    logic             cond;
    logic             take;
    logic [WIDTH-1:0] jalr_sum;
    logic [WIDTH-1:0] target;

    wire zero     = flags[3];
    wire sign     = flags[2];
    wire carry    = flags[1];
    wire overflow = flags[0];

    assign accept = valid_in && ready_in;

    always_comb begin
        cond = 1'b0;
        case (funct3)
            3'b000:  cond = zero;
            3'b001:  cond = !zero;
            3'b100:  cond = sign ^ overflow;
            3'b101:  cond = !(sign ^ overflow);
            3'b110:  cond = carry;
            3'b111:  cond = !carry;
            default: cond = 1'b0;
        endcase
    end

    always_comb begin
        take = 1'b0;
        unique case (1'b1)
            is_branch: take = cond;
            is_jal:    take = 1'b1;
            is_jalr:   take = 1'b1;
            default:   take = 1'b0;
        endcase
    end

    // JALR clears bit 0 of the sum; everything else is pc-relative
    assign jalr_sum = rs1_val + imm;
    assign target   = is_jalr ? {jalr_sum[WIDTH-1:1], 1'b0}
                              : pc + imm;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (accept && take)
                    state_nxt = REDIRECT;
            end
            REDIRECT: begin
                if (redirect_ready) begin
                    if (HAS_FLUSH) begin
                        state_nxt = FLUSH;
                        cnt_nxt   = CNT_LOAD;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            FLUSH: begin
                if (cnt == 4'd0)
                    state_nxt = IDLE;
                else
                    cnt_nxt = cnt - 4'd1;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        ready_in       = (state == IDLE);
        redirect_valid = (state == REDIRECT);
        flush          = (state == FLUSH);
    end

    // Result registers only change on accept, so the target stays put
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resolved    <= 1'b0;
            taken       <= 1'b0;
            link_addr   <= '0;
            redirect_pc <= '0;
        end else begin
            resolved <= accept;
            if (accept) begin
                taken       <= take;
                link_addr   <= pc + WIDTH'(4);
                redirect_pc <= target;
            end
        end
    end

`ifdef BRANCH_RESOLVE_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_resolved <= 32'd0;
            stat_taken    <= 32'd0;
        end else begin
            if (accept)
                stat_resolved <= stat_resolved + 32'd1;
            if (accept && take)
                stat_taken <= stat_taken + 32'd1;
        end
    end
`else
    assign stat_resolved = 32'd0;
    assign stat_taken    = 32'd0;
`endif

endmodule

// File: tb/tb_branch_resolve.sv
// Bench for branch_resolve: directed vector table, hand sequences,
// and random instructions checked against a compare-based model.
module tb_branch_resolve;

    localparam int W  = 32;
    localparam int FC = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          valid_in;
    logic          ready_in;
    logic          is_branch;
    logic          is_jal;
    logic          is_jalr;
    logic [2:0]    funct3;
    logic [3:0]    flags;
    logic [W-1:0]  pc;
    logic [W-1:0]  imm;
    logic [W-1:0]  rs1_val;
    logic          resolved;
    logic          taken;
    logic [W-1:0]  link_addr;
    logic          redirect_valid;
    logic [W-1:0]  redirect_pc;
    logic          redirect_ready;
    logic          flush;
    logic [31:0]   stat_resolved;
    logic [31:0]   stat_taken;

    int checks = 0;
    int errors = 0;

    branch_resolve #(.WIDTH(W), .FLUSH_CYCLES(FC)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .valid_in       (valid_in),
        .ready_in       (ready_in),
        .is_branch      (is_branch),
        .is_jal         (is_jal),
        .is_jalr        (is_jalr),
        .funct3         (funct3),
        .flags          (flags),
        .pc             (pc),
        .imm            (imm),
        .rs1_val        (rs1_val),
        .resolved       (resolved),
        .taken          (taken),
        .link_addr      (link_addr),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .redirect_ready (redirect_ready),
        .flush          (flush),
        .stat_resolved  (stat_resolved),
        .stat_taken     (stat_taken)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  cls;   // 0 none, 1 branch, 2 jal, 3 jalr
        logic [2:0]  f3;
        logic [3:0]  flg;
        logic [31:0] p;
        logic [31:0] im;
        logic [31:0] r1;
        int          stall;
        bit          et;
        logic [31:0] epc;
        string       name;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, " ready_in"}, 64'(ready_in), 64'd1);
        chk({tag, " resolved"}, 64'(resolved), 64'd0);
        chk({tag, " taken"}, 64'(taken), 64'd0);
        chk({tag, " link"}, 64'(link_addr), 64'd0);
        chk({tag, " rvalid"}, 64'(redirect_valid), 64'd0);
        chk({tag, " rpc"}, 64'(redirect_pc), 64'd0);
        chk({tag, " flush"}, 64'(flush), 64'd0);
        chk({tag, " stat_res"}, 64'(stat_resolved), 64'd0);
        chk({tag, " stat_tkn"}, 64'(stat_taken), 64'd0);
    endtask

    task automatic drive(input logic [1:0] cls, input logic [2:0] f3,
                         input logic [3:0] flg, input logic [31:0] p,
                         input logic [31:0] im, input logic [31:0] r1);
        is_branch = (cls == 2'd1);
        is_jal    = (cls == 2'd2);
        is_jalr   = (cls == 2'd3);
        funct3    = f3;
        flags     = flg;
        pc        = p;
        imm       = im;
        rs1_val   = r1;
        valid_in  = 1'b1;
    endtask

    // Called at posedge+1 with the unit idle; returns at posedge+1, idle
    task automatic run(input vec_t v);
        drive(v.cls, v.f3, v.flg, v.p, v.im, v.r1);
        chk({v.name, " ready"}, 64'(ready_in), 64'd1);
        @(posedge clk); #1;
        valid_in = 1'b0;
        chk({v.name, " resolved"}, 64'(resolved), 64'd1);
        chk({v.name, " taken"}, 64'(taken), 64'(v.et));
        chk({v.name, " link"}, 64'(link_addr), 64'(v.p + 32'd4));
        chk({v.name, " rvalid"}, 64'(redirect_valid), 64'(v.et));
        if (v.et) begin
            chk({v.name, " rpc"}, 64'(redirect_pc), 64'(v.epc));
            for (int s = 0; s < v.stall; s++) begin
                @(posedge clk); #1;
                chk({v.name, " stall rv"}, 64'(redirect_valid), 64'd1);
                chk({v.name, " stall rpc"}, 64'(redirect_pc), 64'(v.epc));
                chk({v.name, " stall flush"}, 64'(flush), 64'd0);
            end
            redirect_ready = 1'b1;
            @(posedge clk); #1;
            redirect_ready = 1'b0;
            for (int f = 0; f < FC; f++) begin
                chk({v.name, " flush"}, 64'(flush), 64'd1);
                chk({v.name, " flush rdy"}, 64'(ready_in), 64'd0);
                chk({v.name, " flush rv"}, 64'(redirect_valid), 64'd0);
                @(posedge clk); #1;
            end
            chk({v.name, " end flush"}, 64'(flush), 64'd0);
            chk({v.name, " end rdy"}, 64'(ready_in), 64'd1);
        end else begin
            chk({v.name, " nt ready"}, 64'(ready_in), 64'd1);
            chk({v.name, " nt flush"}, 64'(flush), 64'd0);
        end
    endtask

    function automatic vec_t mk(logic [1:0] cls, logic [2:0] f3,
                                logic [3:0] flg, logic [31:0] p,
                                logic [31:0] im, logic [31:0] r1,
                                int stall, bit et, logic [31:0] epc,
                                string name);
        vec_t v;
        v.cls = cls; v.f3 = f3; v.flg = flg; v.p = p; v.im = im;
        v.r1 = r1; v.stall = stall; v.et = et; v.epc = epc;
        v.name = name;
        return v;
    endfunction

    // Reference: decide from the operands themselves, not the flags
    function automatic bit ref_taken(logic [1:0] cls, logic [2:0] f3,
                                     logic [31:0] a, logic [31:0] b);
        if (cls == 2'd2 || cls == 2'd3) return 1'b1;
        if (cls != 2'd1) return 1'b0;
        case (f3)
            3'd0: return a == b;
            3'd1: return a != b;
            3'd4: return $signed(a) < $signed(b);
            3'd5: return $signed(a) >= $signed(b);
            3'd6: return a < b;
            3'd7: return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] alu_flags(logic [31:0] a, logic [31:0] b);
        logic [31:0] d;
        logic        v;
        d = a - b;
        v = (a[31] != b[31]) && (d[31] != a[31]);
        return {a == b, d[31], a < b, v};
    endfunction

    initial begin
        rst_n = 1'b0;
        valid_in = 1'b0; redirect_ready = 1'b0;
        is_branch = 1'b0; is_jal = 1'b0; is_jalr = 1'b0;
        funct3 = '0; flags = '0; pc = '0; imm = '0; rs1_val = '0;

        vecs.push_back(mk(1, 3'b000, 4'b1000, 32'h100, 32'h20, 0, 0,
                          1, 32'h120, "beq"));
        vecs.push_back(mk(1, 3'b100, 4'b0100, 32'h200, 32'h8, 0, 0,
                          1, 32'h208, "blt"));
        vecs.push_back(mk(1, 3'b110, 4'b0100, 32'h300, 32'h8, 0, 0,
                          0, 0, "bltu"));
        vecs.push_back(mk(1, 3'b101, 4'b0101, 32'h400, 32'hFFFF_FFF8, 0, 0,
                          1, 32'h3F8, "bge_ovf"));
        vecs.push_back(mk(1, 3'b101, 4'b0100, 32'h480, 32'h8, 0, 0,
                          0, 0, "bge_nt"));
        vecs.push_back(mk(3, 3'b000, 4'b0000, 32'h500, 32'h4, 32'h1003, 3,
                          1, 32'h1006, "jalr_stall"));
        vecs.push_back(mk(2, 3'b000, 4'b0000, 32'hFFFF_FFF0, 32'h20, 0, 1,
                          1, 32'h10, "jal_wrap"));
        vecs.push_back(mk(1, 3'b010, 4'b1000, 32'h600, 32'h8, 0, 0,
                          0, 0, "f3_010"));
        vecs.push_back(mk(0, 3'b000, 4'b1000, 32'h700, 32'h8, 0, 0,
                          0, 0, "no_class"));
        vecs.push_back(mk(1, 3'b111, 4'b0000, 32'h800, 32'h40, 0, 0,
                          1, 32'h840, "bgeu"));

        #2;
        chk_reset("reset");
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        foreach (vecs[i]) run(vecs[i]);

        // Back-to-back not-taken BNE, one per cycle
        drive(1, 3'b001, 4'b1000, 32'h900, 32'h40, 0);
        for (int i = 0; i < 4; i++) begin
            pc = 32'h900 + 32'(i * 4);
            @(posedge clk); #1;
            chk("b2b resolved", 64'(resolved), 64'd1);
            chk("b2b taken", 64'(taken), 64'd0);
            chk("b2b link", 64'(link_addr), 64'(32'h904 + 32'(i * 4)));
            chk("b2b ready", 64'(ready_in), 64'd1);
            chk("b2b flush", 64'(flush), 64'd0);
        end
        valid_in = 1'b0;
        @(posedge clk); #1;
        chk("b2b idle resolved", 64'(resolved), 64'd0);

        // Asynchronous reset in the middle of FLUSH
        redirect_ready = 1'b1;
        drive(1, 3'b000, 4'b1000, 32'hA00, 32'h10, 0);
        @(posedge clk); #1;
        valid_in = 1'b0;
        begin
            bit seen = 1'b0;
            for (int k = 0; k < 8 && !seen; k++) begin
                if (flush) seen = 1'b1;
                else begin @(posedge clk); #1; end
            end
            chk("flush seen", 64'(seen), 64'd1);
        end
        #2 rst_n = 1'b0;
        #1 chk_reset("midflush rst");
        @(posedge clk); #1;
        rst_n = 1'b1;
        redirect_ready = 1'b0;
        @(posedge clk); #1;
        chk_reset("after rst");
        run(mk(2, 3'b000, 4'b0000, 32'hB00, 32'h100, 0, 0,
               1, 32'hC00, "post_rst_jal"));
`ifdef BRANCH_RESOLVE_STATS_EN
        chk("stat_resolved", 64'(stat_resolved), 64'd1);
        chk("stat_taken", 64'(stat_taken), 64'd1);
`else
        chk("stat_resolved", 64'(stat_resolved), 64'd0);
        chk("stat_taken", 64'(stat_taken), 64'd0);
`endif

        // Random instructions against the operand-level model
        for (int n = 0; n < 150; n++) begin
            vec_t        v;
            logic [31:0] a, b;
            logic [31:0] r;
            r = $urandom;
            a = $urandom;
            b = (r[1:0] == 2'd0) ? a : $urandom;
            if (r[3:2] == 2'd1) b = ~a;
            v.cls   = (r[7:4] < 4'd10) ? 2'd1 : 2'(r[5:4]);
            v.f3    = 3'($urandom_range(0, 7));
            v.flg   = alu_flags(a, b);
            v.p     = $urandom;
            v.im    = $urandom;
            v.r1    = a;
            v.stall = $urandom_range(0, 2);
            v.et    = ref_taken(v.cls, v.f3, a, b);
            v.epc   = (v.cls == 2'd3) ? ((a + v.im) & ~32'd1)
                                      : v.p + v.im;
            v.name  = $sformatf("rnd%0d", n);
            run(v);
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
